// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters; optional ALU_ARB_STATS_EN adds grant counters
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 4,
  parameter int EXEC_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]      grant_cnt0,
  output logic [15:0]      grant_cnt1,
`endif
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_b1,
  input  logic [SEL_W-1:0] req_sel0,
  input  logic [SEL_W-1:0] req_sel1,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nxt;
  logic last_grant;
  logic [3:0] cnt;
  logic [1:0] grant;
  logic accept, gid, last_exec;
  // on a tie the requester that was not served last wins; otherwise the lone valid one
  always_comb begin
    grant = (&req_valid) ? (last_grant ? 2'b01 : 2'b10) : req_valid;
  end
  assign gid = grant[1];
  assign accept = |req_ready;
  assign last_exec = cnt == 4'd1;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  // next-state logic
  always_comb begin
    state_nxt = state == IDLE ? (accept ? EXEC : IDLE) :
                state == EXEC ? (last_exec ? RESP : EXEC) :
                (rsp_ready ? IDLE : RESP);
  end
  // accept only in IDLE, and only towards the granted requester
  always_comb begin
    req_ready = (state == IDLE) ? grant : 2'b00;
  end
  // operand latch, exec countdown, result capture and response release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      rsp_id <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data <= '0;
      rsp_zero <= 1'b0;
      cnt <= '0;
      last_grant <= 1'b1;
    end else begin
      if (accept) begin
        alu_a <= gid ? req_a1 : req_a0;
        alu_b <= gid ? req_b1 : req_b0;
        alu_sel <= gid ? req_sel1 : req_sel0;
        rsp_id <= gid;
        cnt <= 4'(EXEC_CYCLES);
      end
      if (state == EXEC) begin
        cnt <= cnt - 4'd1;
        if (last_exec) begin
          rsp_data <= alu_result;
          rsp_zero <= alu_zero;
          rsp_valid <= 1'b1;
        end
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        last_grant <= rsp_id;
      end
    end
  end
`ifdef ALU_ARB_STATS_EN
  // saturating per-requester accept counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (req_ready[0] && grant_cnt0 != 16'hFFFF) grant_cnt0 <= grant_cnt0 + 16'd1;
      if (req_ready[1] && grant_cnt1 != 16'hFFFF) grant_cnt1 <= grant_cnt1 + 16'd1;
    end
  end
`endif
endmodule
